// File: rtl/fifo_packet_reader.sv
// Read-side unpacker for the {valid_mask, lane[M-1]..lane[0]} async FIFO packet format.
// Define PKT_RD_RR_ARB_EN for round-robin reader arbitration; the default is fixed priority.
//
// state | meaning
// WAIT  | no packet held; sample FIFO head when not empty
// HAVE  | packet held; serve lowest unconsumed valid lane to a granted reader
// POP   | o_fifo_rinc high this cycle; head advances before WAIT samples again
module fifo_packet_reader #(
    parameter int WIDTH     = 8,
    parameter int M_WRITERS = 2,
    parameter int N_READERS = 2,
    parameter int CNT_W     = 16
) (
    input  logic                                          i_rd_clk,
    input  logic                                          i_rd_rstn,
    input  logic                                          i_fifo_empty,
    input  logic [M_WRITERS*(WIDTH+1)-1:0]                i_fifo_rdata,
    output logic                                          o_fifo_rinc,
    input  logic [N_READERS-1:0]                          i_rd_en,
    output logic [N_READERS-1:0]                          o_rd_gnt,
    output logic                                          o_rd_valid,
    output logic [WIDTH-1:0]                              o_rd_data,
    output logic [((M_WRITERS > 1) ? $clog2(M_WRITERS) : 1)-1:0] o_rd_lane,
    output logic [$clog2(M_WRITERS+1)-1:0]                o_rd_left,
    output logic [CNT_W-1:0]                              o_drop_cnt
);

    localparam int RD_W   = M_WRITERS * (WIDTH + 1);
    localparam int LANE_W = (M_WRITERS > 1) ? $clog2(M_WRITERS) : 1;
    localparam int LEFT_W = $clog2(M_WRITERS + 1);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HAVE = 2'd1,
        POP  = 2'd2
    } state_t;

    state_t                 state;
    logic [RD_W-1:0]        packet_q;
    logic [M_WRITERS-1:0]   consumed_q;

    logic [M_WRITERS-1:0]   mask_q;
    logic [M_WRITERS-1:0]   in_mask;
    logic [M_WRITERS-1:0]   pend;
    logic [M_WRITERS-1:0]   lane_onehot;
    logic [WIDTH-1:0]       lane_data;
    logic [LANE_W-1:0]      lane_idx;
    logic [LEFT_W-1:0]      left_cnt;
    logic                   last_lane;

    logic [N_READERS-1:0]   req_sel;
    logic [N_READERS-1:0]   gnt;

    assign mask_q     = packet_q[RD_W-1 -: M_WRITERS];
    assign in_mask    = i_fifo_rdata[RD_W-1 -: M_WRITERS];
    assign pend       = mask_q & ~consumed_q;
    assign o_rd_valid = (state == HAVE);

    // Descending scan so the lowest pending lane is the one left selected.
    always_comb begin
        lane_data   = '0;
        lane_idx    = '0;
        lane_onehot = '0;
        left_cnt    = '0;
        for (int k = M_WRITERS - 1; k >= 0; k--) begin
            if (pend[k]) begin
                lane_data      = packet_q[k*WIDTH +: WIDTH];
                lane_idx       = LANE_W'(k);
                lane_onehot    = '0;
                lane_onehot[k] = 1'b1;
                left_cnt       = left_cnt + LEFT_W'(1);
            end
        end
    end

    assign last_lane = (left_cnt == LEFT_W'(1));

    assign o_rd_data = o_rd_valid ? lane_data : '0;
    assign o_rd_lane = o_rd_valid ? lane_idx  : '0;
    assign o_rd_left = o_rd_valid ? left_cnt  : '0;

`ifdef PKT_RD_RR_ARB_EN
    localparam int PTR_W = (N_READERS > 1) ? $clog2(N_READERS) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [N_READERS-1:0] hi_mask;
    logic [N_READERS-1:0] req_hi;

    // Requests at or above the pointer win; otherwise wrap to the lowest requester.
    assign hi_mask = ~((N_READERS'(1) << rr_ptr) - N_READERS'(1));
    assign req_hi  = i_rd_en & hi_mask;
    assign req_sel = (|req_hi) ? req_hi : i_rd_en;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = N_READERS - 1; i >= 0; i--) begin
            if (req_sel[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        if (!o_rd_valid) begin
            gnt = '0;
        end
    end

    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (int'(gnt_idx) == N_READERS - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end
`else
    assign req_sel = i_rd_en;

    always_comb begin
        gnt = '0;
        for (int i = N_READERS - 1; i >= 0; i--) begin
            if (req_sel[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
        if (!o_rd_valid) begin
            gnt = '0;
        end
    end
`endif

    assign o_rd_gnt = gnt;

    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
        if (!i_rd_rstn) begin
            state       <= WAIT;
            packet_q    <= '0;
            consumed_q  <= '0;
            o_fifo_rinc <= 1'b0;
            o_drop_cnt  <= '0;
        end else begin
            o_fifo_rinc <= 1'b0;
            case (state)
                WAIT: begin
                    if (!i_fifo_empty) begin
                        if (in_mask != '0) begin
                            packet_q   <= i_fifo_rdata;
                            consumed_q <= '0;
                            state      <= HAVE;
                        end else begin
                            if (o_drop_cnt != '1) begin
                                o_drop_cnt <= o_drop_cnt + CNT_W'(1);
                            end
                            o_fifo_rinc <= 1'b1;
                            state       <= POP;
                        end
                    end
                end
                HAVE: begin
                    if (|gnt) begin
                        consumed_q <= consumed_q | lane_onehot;
                        if (last_lane) begin
                            o_fifo_rinc <= 1'b1;
                            state       <= POP;
                        end
                    end
                end
                POP: begin
                    state <= WAIT;
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

endmodule
